// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared widths, FSM states and operand type for the divider feeder
package divider_pkg;

  localparam int DIVIDEND_W  = 8;
  localparam int DIVISOR_W   = 7;
  localparam int QUOTIENT_W  = 8;
  localparam int REMAINDER_W = 7;

  localparam logic [QUOTIENT_W-1:0] DBZ_QUOTIENT = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_LOW,
    ST_WAIT_HIGH,
    ST_HOLD
  } feeder_state_t;

  typedef struct packed {
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
  } operand_t;

endpackage

// File: rtl/feeder_fifo.sv
// rtl/feeder_fifo.sv - synchronous operand FIFO with a registered head entry
module feeder_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_head;
  logic             w_push;
  logic             w_pop;
  logic [AW-1:0]    w_rd_next;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_head;
  assign w_push    = i_push && !o_full;
  assign w_pop     = i_pop && !o_empty;
  assign w_rd_next = r_rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= w_rd_next;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
      // Head tracks the oldest entry; with a single entry the next head is the incoming word.
      if (w_pop) begin
        if (r_count > ONE_CNT) r_head <= r_mem[w_rd_next];
        else if (w_push)       r_head <= i_data;
      end else if (w_push && o_empty) begin
        r_head <= i_data;
      end
    end
  end

endmodule

// File: rtl/divider_feeder.sv
// rtl/divider_feeder.sv - queues operand pairs, drives the sequential divider, returns results
// Optional divide-by-zero bypass: FEEDER_DBZ_BYPASS_EN
module divider_feeder
  import divider_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 31
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DIVIDEND_W-1:0]  in_dividend,
  input  logic [DIVISOR_W-1:0]   in_divisor,
  output logic                   div_start,
  output logic [DIVIDEND_W-1:0]  div_dividend,
  output logic [DIVISOR_W-1:0]   div_divisor,
  input  logic                   div_valid,
  input  logic [QUOTIENT_W-1:0]  div_quotient,
  input  logic [REMAINDER_W-1:0] div_remainder,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [QUOTIENT_W-1:0]  out_quotient,
  output logic [REMAINDER_W-1:0] out_remainder,
  output logic                   out_dbz,
  output logic                   out_timeout,
  output logic                   busy
);

  feeder_state_t          r_state;
  feeder_state_t          w_state_next;
  operand_t               r_op;
  logic [7:0]             r_tmo_cnt;
  logic [QUOTIENT_W-1:0]  r_quot;
  logic [REMAINDER_W-1:0] r_rem;
  logic                   r_timeout;

  operand_t               w_in_op;
  operand_t               w_head;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [$clog2(DEPTH):0] w_fifo_count;
  logic                   w_head_dbz;
  logic                   w_tmo_hit;

  assign w_in_op = {in_dividend, in_divisor};
  assign w_push  = in_valid && in_ready;

  feeder_fifo #(
    .DEPTH(DEPTH),
    .WIDTH($bits(operand_t))
  ) u_fifo (
    .clk    (clk),
    .rst_n  (reset),
    .i_push (w_push),
    .i_data (w_in_op),
    .i_pop  (w_pop),
    .o_head (w_head),
    .o_full (w_fifo_full),
    .o_empty(w_fifo_empty),
    .o_count(w_fifo_count)
  );

`ifdef FEEDER_DBZ_BYPASS_EN
  logic r_dbz;

  assign w_head_dbz = (w_head.divisor == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     r_dbz <= 1'b0;
    else if (w_pop) r_dbz <= w_head_dbz;
  end

  assign out_dbz = r_dbz;
`else
  assign w_head_dbz = 1'b0;
  assign out_dbz    = 1'b0;
`endif

  // The counter equals the number of completed wait cycles, so this is the last allowed one.
  assign w_tmo_hit = (r_tmo_cnt == 8'(TIMEOUT - 1));

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_state_next = w_head_dbz ? ST_HOLD : ST_ISSUE;
        end
      end
      ST_ISSUE:     w_state_next = ST_WAIT_LOW;
      ST_WAIT_LOW: begin
        if (w_tmo_hit)       w_state_next = ST_HOLD;
        else if (!div_valid) w_state_next = ST_WAIT_HIGH;
      end
      ST_WAIT_HIGH: begin
        if (div_valid || w_tmo_hit) w_state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) w_state_next = ST_IDLE;
      end
      default:      w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_op      <= '0;
      r_tmo_cnt <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_pop) r_op <= w_head;
      case (r_state)
        ST_IDLE: begin
          if (w_pop && w_head_dbz) begin
            r_quot    <= DBZ_QUOTIENT;
            r_rem     <= w_head.dividend[REMAINDER_W-1:0];
            r_timeout <= 1'b0;
          end
        end
        ST_ISSUE: r_tmo_cnt <= '0;
        ST_WAIT_LOW, ST_WAIT_HIGH: begin
          r_tmo_cnt <= r_tmo_cnt + 1'b1;
          // A real result beats the timeout when both land in the same cycle.
          if (r_state == ST_WAIT_HIGH && div_valid) begin
            r_quot    <= div_quotient;
            r_rem     <= div_remainder;
            r_timeout <= 1'b0;
          end else if (w_tmo_hit) begin
            r_quot    <= '0;
            r_rem     <= '0;
            r_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready      = !w_fifo_full;
  assign div_start     = (r_state == ST_ISSUE);
  assign div_dividend  = r_op.dividend;
  assign div_divisor   = r_op.divisor;
  assign out_valid     = (r_state == ST_HOLD);
  assign out_quotient  = r_quot;
  assign out_remainder = r_rem;
  assign out_timeout   = r_timeout;
  assign busy          = (r_state != ST_IDLE) || (w_fifo_count != '0);

endmodule

// File: tb/tb_divider_feeder.sv
// tb/tb_divider_feeder.sv - scoreboard bench for divider_feeder with a behavioural divider
module tb_divider_feeder;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 31;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready;
  logic [7:0] in_dividend;
  logic [6:0] in_divisor;
  logic       div_start;
  logic [7:0] div_dividend;
  logic [6:0] div_divisor;
  logic       div_valid;
  logic [7:0] div_quotient;
  logic [6:0] div_remainder;
  logic       out_valid, out_ready;
  logic [7:0] out_quotient;
  logic [6:0] out_remainder;
  logic       out_dbz, out_timeout, busy;

  divider_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_dividend(in_dividend), .in_divisor(in_divisor),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_valid(div_valid), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .out_valid(out_valid), .out_ready(out_ready), .out_quotient(out_quotient),
    .out_remainder(out_remainder), .out_dbz(out_dbz), .out_timeout(out_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [7:0] q;
    logic [6:0] r;
    logic       dbz;
    logic       tmo;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Divider model: holds valid until two cycles after the next start (stale valid), latency lat.
  int         lat = 8;
  bit         never_valid = 0;
  int         starts = 0;
  int         t_dv = 0;
  int         m_cnt = 0;
  bit         m_pend = 0;
  logic [7:0] m_q;
  logic [6:0] m_r;

  initial begin
    div_valid = 0; div_quotient = 0; div_remainder = 0; m_q = 0; m_r = 0;
    forever begin
      @(posedge clk); #2;
      if (!reset) begin
        div_valid = 0; m_pend = 0;
      end else if (div_start) begin
        starts++; m_pend = 1; m_cnt = lat;
        if (div_divisor == 0) begin
          m_q = 8'hFF; m_r = div_dividend[6:0];
        end else begin
          m_q = 8'(div_dividend / {1'b0, div_divisor});
          m_r = 7'(div_dividend % {1'b0, div_divisor});
        end
      end else if (m_pend) begin
        m_cnt--;
        if (m_cnt == lat - 2) div_valid = 0;
        if (m_cnt == 0) begin
          m_pend = 0;
          if (!never_valid) begin
            div_valid = 1; div_quotient = m_q; div_remainder = m_r; t_dv = cyc;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_result: got q=%0d r=%0d, expected no result", out_quotient, out_remainder);
      end else begin
        e = sb.pop_front();
        check("result_q",       out_quotient,  e.q);
        check("result_r",       out_remainder, e.r);
        check("result_dbz",     out_dbz,       e.dbz);
        check("result_timeout", out_timeout,   e.tmo);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [7:0] a, input logic [6:0] b, input logic [7:0] eq,
                      input logic [6:0] er, input logic edbz, input logic etmo);
    exp_t e;
    int g = 0;
    in_valid = 1; in_dividend = a; in_divisor = b;
    while (!in_ready && g < 200) begin tick(1); g++; end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL push_accept: got in_ready=0 expected 1 within 200 cycles");
      in_valid = 0;
      return;
    end
    e.q = eq; e.r = er; e.dbz = edbz; e.tmo = etmo;
    sb.push_back(e);
    tick(1);
    in_valid = 0;
  endtask

  task automatic wait_out_valid(input string name);
    int g = 0;
    while (!out_valid && g < 100) begin tick(1); g++; end
    check(name, int'(out_valid), 1);
  endtask

  task automatic wait_idle(input string name);
    int g = 0;
    while ((busy || out_valid) && g < 300) begin tick(1); g++; end
    check(name, int'(busy || out_valid), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, t0, t1;
    bit stable;
    logic [7:0] q0;
    logic [6:0] r0;

    reset = 1; in_valid = 0; in_dividend = 0; in_divisor = 0; out_ready = 1;
    #2 reset = 0;
    tick(3);
    check("rst_in_ready",  in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_div_start", div_start, 0);
    check("rst_busy",      busy, 0);
    check("rst_outputs",   int'({out_quotient, out_remainder, out_dbz, out_timeout}), 0);
    check("rst_div_ops",   int'({div_dividend, div_divisor}), 0);
    reset = 1;
    tick(2);

    // 100/7 = 14 r 2
    s0 = starts;
    push(8'd100, 7'd7, 8'd14, 7'd2, 0, 0);
    check("t1_no_start_yet", div_start, 0);
    tick(1);
    check("t1_start_latency", div_start, 1);
    wait_out_valid("t1_out_valid");
    check("t1_out_after_div_valid", cyc - t_dv, 1);
    check("t1_single_start", starts - s0, 1);
    wait_idle("t1_idle");

    // zero divisor
    s0 = starts;
`ifdef FEEDER_DBZ_BYPASS_EN
    out_ready = 0;
    push(8'h5A, 7'd0, 8'hFF, 7'h5A, 1, 0);
    check("dbz_not_yet", out_valid, 0);
    tick(1);
    check("dbz_latency", out_valid, 1);
    tick(2);
    check("dbz_no_start", starts - s0, 0);
    out_ready = 1;
`else
    push(8'h5A, 7'd0, 8'hFF, 7'h5A, 0, 0);
    wait_out_valid("zdiv_out_valid");
    check("zdiv_issued", starts - s0, 1);
`endif
    wait_idle("dbz_idle");

    // back-to-back pushes with the consumer stalled
    out_ready = 0;
    s0 = starts;
    push(8'd200, 7'd3,   8'd66,  7'd2, 0, 0);
    push(8'd9,   7'd9,   8'd1,   7'd0, 0, 0);
    push(8'd255, 7'd1,   8'd255, 7'd0, 0, 0);
    push(8'd7,   7'd100, 8'd0,   7'd7, 0, 0);
    check("b2b_not_full", in_ready, 1);
    wait_out_valid("b2b_first_result");
    q0 = out_quotient; r0 = out_remainder;
    push(8'd50, 7'd5, 8'd10, 7'd0, 0, 0);
    check("b2b_full_in_ready", in_ready, 0);
    stable = 1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (!out_valid || out_quotient != q0 || out_remainder != r0 || in_ready) stable = 0;
    end
    check("hold_stable", int'(stable), 1);
    check("hold_no_second_start", starts - s0, 1);
    out_ready = 1;
    wait_idle("b2b_idle");
    check("b2b_all_drained", sb.size(), 0);
    check("b2b_start_count", starts - s0, 5);

    // timeout then a normal operand
    never_valid = 1;
    push(8'd33, 7'd4, 8'd0, 7'd0, 0, 1);
    push(8'd20, 7'd6, 8'd3, 7'd2, 0, 0);
    check("tmo_start", div_start, 1);
    tick(1);
    t0 = cyc;
    wait_out_valid("tmo_hold");
    t1 = cyc;
    never_valid = 0;
    check("tmo_cycles", t1 - t0, TIMEOUT);
    check("tmo_flag", out_timeout, 1);
    wait_idle("tmo_idle");
    check("tmo_drained", sb.size(), 0);

    // reset during WAIT_HIGH with two entries queued
    push(8'd10, 7'd2, 8'd5, 7'd0, 0, 0);
    push(8'd11, 7'd3, 8'd3, 7'd2, 0, 0);
    push(8'd12, 7'd4, 8'd3, 7'd0, 0, 0);
    tick(4);
    check("mid_busy", busy, 1);
    reset = 0;
    sb.delete();
    #1;
    check("mid_rst_div_start", div_start, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy",      busy, 0);
    check("mid_rst_in_ready",  in_ready, 1);
    tick(2);
    reset = 1;
    s0 = starts;
    tick(40);
    check("post_rst_no_start", starts - s0, 0);
    check("post_rst_no_valid", out_valid, 0);
    check("final_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
